// File: rtl/slip_tx_if.sv
// Byte-stream handshake between a frame producer and the SLIP transmitter.
// A byte transfers on a clock edge where i_byte_valid and o_byte_ready are both high.
interface slip_tx_if;
    logic       i_byte_valid;
    logic [7:0] i_byte;
    logic       o_byte_ready;
    logic       i_frame_end;

    modport master (
        output i_byte_valid,
        output i_byte,
        output i_frame_end,
        input  o_byte_ready
    );

    modport slave (
        input  i_byte_valid,
        input  i_byte,
        input  i_frame_end,
        output o_byte_ready
    );
endinterface

// File: rtl/slip_tx.sv
// SLIP frame encoder feeding an 8N1 UART transmitter; escapes 0xC0/0xDB, closes frames with END.
// Optional SLIP_TX_LEADING_END_EN: send an END before the payload to flush receiver noise.
module slip_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_frame_start,
    slip_tx_if.slave   bus,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_uart_tx
);
    typedef enum logic [2:0] {
        F_IDLE, F_START_END, F_WAIT, F_SEND, F_SEND_END, F_DONE
    } f_state_t;
    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;

    localparam logic [15:0] LP_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LP_ALMOST = 16'(CLKS_PER_BIT - 2);

    f_state_t    r_f_state, w_f_nxt;
    logic        r_end_latched, w_end_latched_nxt;
    logic        r_end_loaded, w_end_loaded_nxt;
    logic        r_esc_pending, w_esc_pending_nxt;
    logic [7:0]  r_esc_char, w_esc_char_nxt;

    u_state_t    r_u_state, w_u_nxt;
    logic [15:0] r_timer, w_timer_nxt;
    logic [2:0]  r_bit_idx, w_bit_idx_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_tx, w_tx_nxt;

    logic        w_load;
    logic [7:0]  w_load_char;
    logic        w_bit_end, w_char_end, w_uart_free, w_almost, w_hs;

    assign w_bit_end   = (r_timer == LP_LAST);
    assign w_char_end  = (r_u_state == U_STOP) && w_bit_end;
    assign w_uart_free = (r_u_state == U_IDLE) || w_char_end;
    // One cycle before the stop bit ends, so the next char can be loaded without a gap.
    assign w_almost    = (r_u_state == U_STOP) && (r_timer == LP_ALMOST);
    assign w_hs        = bus.i_byte_valid && (r_f_state == F_WAIT);

    assign bus.o_byte_ready = (r_f_state == F_WAIT);
    assign o_busy           = (r_f_state != F_IDLE) && (r_f_state != F_DONE);
    assign o_frame_done     = (r_f_state == F_DONE);
    assign o_uart_tx        = r_tx;

    always_comb begin
        w_f_nxt           = r_f_state;
        w_end_latched_nxt = r_end_latched;
        w_end_loaded_nxt  = r_end_loaded;
        w_esc_pending_nxt = r_esc_pending;
        w_esc_char_nxt    = r_esc_char;
        w_load            = 1'b0;
        w_load_char       = 8'hC0;
        case (r_f_state)
            F_IDLE: begin
                if (i_frame_start) begin
                    w_end_latched_nxt = 1'b0;
                    w_end_loaded_nxt  = 1'b0;
                    w_esc_pending_nxt = 1'b0;
`ifdef SLIP_TX_LEADING_END_EN
                    w_load  = 1'b1;
                    w_f_nxt = F_START_END;
`else
                    w_f_nxt = F_WAIT;
`endif
                end
            end
            F_START_END: begin
                if (w_char_end) w_f_nxt = F_WAIT;
            end
            F_WAIT: begin
                if (w_hs) begin
                    w_load            = 1'b1;
                    w_end_latched_nxt = bus.i_frame_end;
                    w_f_nxt           = F_SEND;
                    if (bus.i_byte == 8'hC0 || bus.i_byte == 8'hDB) begin
                        w_load_char       = 8'hDB;
                        w_esc_pending_nxt = 1'b1;
                        w_esc_char_nxt    = (bus.i_byte == 8'hC0) ? 8'hDC : 8'hDD;
                    end else begin
                        w_load_char = bus.i_byte;
                    end
                end else if (bus.i_frame_end) begin
                    w_load           = 1'b1;
                    w_end_loaded_nxt = 1'b1;
                    w_f_nxt          = F_SEND_END;
                end
            end
            F_SEND: begin
                if (r_esc_pending) begin
                    if (w_uart_free) begin
                        w_load            = 1'b1;
                        w_load_char       = r_esc_char;
                        w_esc_pending_nxt = 1'b0;
                    end
                end else if (w_almost) begin
                    w_f_nxt          = r_end_latched ? F_SEND_END : F_WAIT;
                    w_end_loaded_nxt = 1'b0;
                end
            end
            F_SEND_END: begin
                if (!r_end_loaded) begin
                    if (w_uart_free) begin
                        w_load           = 1'b1;
                        w_end_loaded_nxt = 1'b1;
                    end
                end else if (w_char_end) begin
                    w_f_nxt = F_DONE;
                end
            end
            F_DONE:  w_f_nxt = F_IDLE;
            default: w_f_nxt = F_IDLE;
        endcase
    end

    always_comb begin
        w_u_nxt       = r_u_state;
        w_timer_nxt   = w_bit_end ? 16'd0 : r_timer + 16'd1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        if (w_load) begin
            w_u_nxt       = U_START;
            w_timer_nxt   = 16'd0;
            w_bit_idx_nxt = 3'd0;
            w_shift_nxt   = w_load_char;
            w_tx_nxt      = 1'b0;
        end else begin
            case (r_u_state)
                U_IDLE: begin
                    w_timer_nxt = 16'd0;
                    w_tx_nxt    = 1'b1;
                end
                U_START: begin
                    if (w_bit_end) begin
                        w_u_nxt  = U_DATA;
                        w_tx_nxt = r_shift[0];
                    end
                end
                U_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            w_u_nxt  = U_STOP;
                            w_tx_nxt = 1'b1;
                        end else begin
                            w_bit_idx_nxt = r_bit_idx + 3'd1;
                            w_shift_nxt   = {1'b0, r_shift[7:1]};
                            w_tx_nxt      = r_shift[1];
                        end
                    end
                end
                U_STOP: begin
                    if (w_bit_end) w_u_nxt = U_IDLE;
                end
                default: w_u_nxt = U_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_f_state     <= F_IDLE;
            r_end_latched <= 1'b0;
            r_end_loaded  <= 1'b0;
            r_esc_pending <= 1'b0;
            r_esc_char    <= 8'h00;
            r_u_state     <= U_IDLE;
            r_timer       <= 16'd0;
            r_bit_idx     <= 3'd0;
            r_shift       <= 8'h00;
            r_tx          <= 1'b1;
        end else begin
            r_f_state     <= w_f_nxt;
            r_end_latched <= w_end_latched_nxt;
            r_end_loaded  <= w_end_loaded_nxt;
            r_esc_pending <= w_esc_pending_nxt;
            r_esc_char    <= w_esc_char_nxt;
            r_u_state     <= w_u_nxt;
            r_timer       <= w_timer_nxt;
            r_bit_idx     <= w_bit_idx_nxt;
            r_shift       <= w_shift_nxt;
            r_tx          <= w_tx_nxt;
        end
    end
endmodule
